// File: rtl/ic_cpu_bus_axi_bridge_mo.sv
`default_nettype none
// ============================================================================
// Module   : ic_cpu_bus_axi_bridge_mo
// Purpose  : CPU req/gnt + recv/ack port to AXI4-Lite master bridge with up to
//            OUTSTANDING in-flight transactions, responses in request order.
// Revision : 1.0 - initial release
// ============================================================================
module ic_cpu_bus_axi_bridge_mo #(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter int         OUTSTANDING = 4,
  parameter logic [2:0] PROT        = 3'b000
) (
  input  logic                m0_aclk,
  input  logic                m0_aresetn,
  // AW
  output logic                m0_awvalid,
  input  logic                m0_awready,
  output logic [ADDR_W-1:0]   m0_awaddr,
  output logic [2:0]          m0_awprot,
  // W
  output logic                m0_wvalid,
  input  logic                m0_wready,
  output logic [DATA_W-1:0]   m0_wdata,
  output logic [DATA_W/8-1:0] m0_wstrb,
  // B
  input  logic                m0_bvalid,
  output logic                m0_bready,
  input  logic [1:0]          m0_bresp,
  // AR
  output logic                m0_arvalid,
  input  logic                m0_arready,
  output logic [ADDR_W-1:0]   m0_araddr,
  output logic [2:0]          m0_arprot,
  // R
  input  logic                m0_rvalid,
  output logic                m0_rready,
  input  logic [1:0]          m0_rresp,
  input  logic [DATA_W-1:0]   m0_rdata,
  // CPU side
  input  logic                enable,
  input  logic                mem_req,
  output logic                mem_gnt,
  input  logic                mem_wen,
  input  logic [DATA_W/8-1:0] mem_strb,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_recv,
  input  logic                mem_ack,
  output logic                mem_error,
  output logic [DATA_W-1:0]   mem_rdata
);

  localparam int               CNT_W  = $clog2(OUTSTANDING + 1);
  localparam int               STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(OUTSTANDING);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]       r_cnt;
  logic [OUTSTANDING-1:0] r_order;
  logic                   r_arvalid;
  logic [ADDR_W-1:0]      r_araddr;
  logic                   r_awvalid;
  logic [ADDR_W-1:0]      r_awaddr;
  logic                   r_wvalid;
  logic [DATA_W-1:0]      r_wdata;
  logic [STRB_W-1:0]      r_wstrb;

  logic                   w_head;
  logic                   w_nonempty;
  logic                   w_rsp;
  logic                   w_ar_free;
  logic                   w_aw_free;
  logic                   w_w_free;
  logic                   w_acc;
  logic                   w_acc_rd;
  logic                   w_acc_wr;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_push_idx;
  logic [OUTSTANDING-1:0] w_order_nxt;
  logic                   w_unused;

  // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign w_unused = ^{m0_bresp[0], m0_rresp[0]};

  // Order FIFO is a shift register: bit 0 is the oldest entry's type (1=write).
  assign w_head     = r_order[0];
  assign w_nonempty = (r_cnt != '0);

  assign mem_recv   = w_nonempty & (w_head ? m0_bvalid : m0_rvalid);
  assign m0_bready  = w_nonempty & w_head & mem_ack;
  assign m0_rready  = w_nonempty & ~w_head & mem_ack;
  assign mem_error  = w_head ? m0_bresp[1] : m0_rresp[1];
  assign mem_rdata  = m0_rdata;
  assign w_rsp      = mem_recv & mem_ack;

  assign w_ar_free  = ~r_arvalid | m0_arready;
  assign w_aw_free  = ~r_awvalid | m0_awready;
  assign w_w_free   = ~r_wvalid  | m0_wready;

  // Grant is gated by reset so the CPU never sees gnt while the bridge is held.
  assign mem_gnt    = m0_aresetn & enable & ((r_cnt < C_MAX) | w_rsp) &
                      (mem_wen ? (w_aw_free & w_w_free) : w_ar_free);
  assign w_acc      = mem_req & mem_gnt;
  assign w_acc_rd   = w_acc & ~mem_wen;
  assign w_acc_wr   = w_acc & mem_wen;

  assign m0_arvalid = r_arvalid;
  assign m0_araddr  = r_araddr;
  assign m0_arprot  = PROT;
  assign m0_awvalid = r_awvalid;
  assign m0_awaddr  = r_awaddr;
  assign m0_awprot  = PROT;
  assign m0_wvalid  = r_wvalid;
  assign m0_wdata   = r_wdata;
  assign m0_wstrb   = r_wstrb;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_acc, w_rsp})
      2'b10:   w_cnt_nxt = r_cnt + C_ONE;
      2'b01:   w_cnt_nxt = r_cnt - C_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Pop shifts first, so a same-cycle push lands one slot lower.
  always_comb begin
    w_order_nxt = w_rsp ? (r_order >> 1) : r_order;
    w_push_idx  = r_cnt - (w_rsp ? C_ONE : '0);
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (w_acc && (w_push_idx == CNT_W'(i))) begin
        w_order_nxt[i] = mem_wen;
      end
    end
  end

  always_ff @(posedge m0_aclk or negedge m0_aresetn) begin
    if (!m0_aresetn) begin
      r_cnt     <= '0;
      r_order   <= '0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_order <= w_order_nxt;

      if (w_acc_rd) begin
        r_arvalid <= 1'b1;
        r_araddr  <= mem_addr;
      end else if (m0_arready) begin
        r_arvalid <= 1'b0;
      end

      // AW and W retire independently; a refill keeps valid high with new payload.
      if (w_acc_wr) begin
        r_awvalid <= 1'b1;
        r_awaddr  <= mem_addr;
        r_wvalid  <= 1'b1;
        r_wdata   <= mem_wdata;
        r_wstrb   <= mem_strb;
      end else begin
        if (m0_awready) r_awvalid <= 1'b0;
        if (m0_wready)  r_wvalid  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ic_cpu_bus_axi_bridge_mo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ic_cpu_bus_axi_bridge_mo
// Purpose  : Directed and randomized bench for ic_cpu_bus_axi_bridge_mo with an
//            AXI4-Lite slave model and an in-order response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ic_cpu_bus_axi_bridge_mo;

  localparam int          OUT     = 4;
  localparam logic [31:0] C_RMASK = 32'h5A5A_0000;

  logic        m0_aclk;
  logic        m0_aresetn;
  logic        m0_awvalid, m0_awready;
  logic [31:0] m0_awaddr;
  logic [2:0]  m0_awprot;
  logic        m0_wvalid, m0_wready;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_bvalid, m0_bready;
  logic [1:0]  m0_bresp;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_araddr;
  logic [2:0]  m0_arprot;
  logic        m0_rvalid, m0_rready;
  logic [1:0]  m0_rresp;
  logic [31:0] m0_rdata;
  logic        enable, mem_req, mem_gnt, mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_recv, mem_ack, mem_error;
  logic [31:0] mem_rdata;

  ic_cpu_bus_axi_bridge_mo #(
    .ADDR_W(32), .DATA_W(32), .OUTSTANDING(OUT), .PROT(3'b000)
  ) dut (
    .m0_aclk(m0_aclk), .m0_aresetn(m0_aresetn),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
    .enable(enable), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata)
  );

  initial m0_aclk = 1'b0;
  always #5 m0_aclk = ~m0_aclk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
  } ent_t;

  // Reference model: CPU-order scoreboard plus slave-side queues.
  ent_t        ord[$];
  logic [31:0] exp_ar[$], exp_aw[$], r_pend[$], aw_got[$];
  logic [35:0] exp_w[$];
  int          w_got;
  logic        r_allow, b_allow, r_hold, b_hold;

  int          checks, errors, cyc, acc_cyc, ret_cyc, n_ret;
  logic        s_gnt, s_recv, s_bready, s_err;
  logic [31:0] s_rdata;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ C_RMASK;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic req, input logic wen, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] strb);
    mem_req   = req;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_wdata = data;
    mem_strb  = strb;
  endtask

  task automatic model_clear();
    ord.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    r_pend.delete(); aw_got.delete();
    w_got = 0; r_hold = 1'b0; b_hold = 1'b0;
  endtask

  // One clock cycle: drive slave responses, check against the model, advance.
  task automatic step();
    logic have, hw, exp_recv, rsp, ar_free, aw_free, w_free, exp_gnt;
    ent_t e;
    m0_rvalid = (r_pend.size() > 0) && (r_allow || r_hold);
    m0_rdata  = (r_pend.size() > 0) ? rdata_of(r_pend[0]) : 32'h0;
    m0_rresp  = ((r_pend.size() > 0) && r_pend[0][4]) ? 2'b10 : 2'b00;
    m0_bvalid = (aw_got.size() > 0) && (w_got > 0) && (b_allow || b_hold);
    m0_bresp  = ((aw_got.size() > 0) && aw_got[0][5]) ? 2'b11 : 2'b01;
    #1;
    chk("arvalid", m0_arvalid, exp_ar.size() != 0);
    chk("awvalid", m0_awvalid, exp_aw.size() != 0);
    chk("wvalid",  m0_wvalid,  exp_w.size()  != 0);
    have     = ord.size() != 0;
    hw       = have && ord[0].wen;
    exp_recv = have && (hw ? m0_bvalid : m0_rvalid);
    chk("recv",   mem_recv,  exp_recv);
    chk("bready", m0_bready, have && hw && mem_ack);
    chk("rready", m0_rready, have && !hw && mem_ack);
    rsp     = exp_recv && mem_ack;
    ar_free = (exp_ar.size() == 0) || m0_arready;
    aw_free = (exp_aw.size() == 0) || m0_awready;
    w_free  = (exp_w.size()  == 0) || m0_wready;
    exp_gnt = enable && ((ord.size() < OUT) || rsp) && (mem_wen ? (aw_free && w_free) : ar_free);
    chk("gnt", mem_gnt, exp_gnt);
    s_gnt = mem_gnt; s_recv = mem_recv; s_bready = m0_bready;

    if ((exp_ar.size() != 0) && m0_arready) begin
      chk("araddr", m0_araddr, exp_ar[0]);
      chk("arprot", m0_arprot, 3'b000);
      r_pend.push_back(exp_ar.pop_front());
    end
    if ((exp_aw.size() != 0) && m0_awready) begin
      chk("awaddr", m0_awaddr, exp_aw[0]);
      chk("awprot", m0_awprot, 3'b000);
      aw_got.push_back(exp_aw.pop_front());
    end
    if ((exp_w.size() != 0) && m0_wready) begin
      chk("wdata_strb", {m0_wstrb, m0_wdata}, exp_w[0]);
      void'(exp_w.pop_front());
      w_got++;
    end
    if (rsp) begin
      e = ord.pop_front();
      chk("error", mem_error, e.wen ? e.addr[5] : e.addr[4]);
      if (!e.wen) begin
        chk("rdata", mem_rdata, rdata_of(e.addr));
        void'(r_pend.pop_front());
      end else begin
        void'(aw_got.pop_front());
        w_got--;
      end
      s_err = mem_error; s_rdata = mem_rdata; ret_cyc = cyc; n_ret++;
    end
    r_hold = m0_rvalid && !(rsp && !hw);
    b_hold = m0_bvalid && !(rsp && hw);
    if (mem_req && exp_gnt) begin
      ord.push_back('{wen: mem_wen, addr: mem_addr});
      if (mem_wen) begin
        exp_aw.push_back(mem_addr);
        exp_w.push_back({mem_strb, mem_wdata});
      end else begin
        exp_ar.push_back(mem_addr);
      end
      acc_cyc = cyc;
    end
    @(posedge m0_aclk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (n) step();
  endtask

  task automatic single_read_dead();
    int n0;
    m0_arready = 1'b1; r_allow = 1'b1; mem_ack = 1'b1;
    n0 = n_ret;
    cpu(1'b1, 1'b0, 32'hDEADBEEF ^ C_RMASK, 32'h0, 4'h0);
    step();
    idle_steps(3);
    chk("t1_latency", ret_cyc - acc_cyc, 2);
    chk("t1_rdata",   s_rdata, 32'hDEADBEEF);
    chk("t1_error",   s_err, 1'b0);
    chk("t1_retired", n_ret - n0, 1);
  endtask

  initial begin
    int n0;
    checks = 0; errors = 0; cyc = 0; n_ret = 0; acc_cyc = 0; ret_cyc = 0;
    s_err = 1'b0; s_rdata = '0;
    model_clear();
    r_allow = 1'b0; b_allow = 1'b0;
    m0_aresetn = 1'b0; enable = 1'b1; mem_ack = 1'b1;
    m0_awready = 1'b0; m0_wready = 1'b0; m0_arready = 1'b0;
    m0_rvalid = 1'b0; m0_bvalid = 1'b0; m0_rresp = 2'b00; m0_bresp = 2'b00; m0_rdata = '0;
    cpu(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    repeat (2) @(posedge m0_aclk);
    #1;
    chk("rst_gnt",     mem_gnt, 1'b0);
    chk("rst_recv",    mem_recv, 1'b0);
    chk("rst_valids",  {m0_arvalid, m0_awvalid, m0_wvalid}, 3'b000);
    chk("rst_readies", {m0_bready, m0_rready}, 2'b00);
    m0_aresetn = 1'b1;
    cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge m0_aclk);
    #1;

    // 1: single read, minimum latency
    single_read_dead();

    // 2: write, W accepted three cycles before AW
    m0_awready = 1'b0; m0_wready = 1'b1; b_allow = 1'b1; mem_ack = 1'b1;
    n0 = n_ret;
    cpu(1'b1, 1'b1, 32'h100, 32'h1234, 4'b0011);
    step();
    idle_steps(1);
    chk("t2_wvalid_dropped", m0_wvalid, 1'b0);
    chk("t2_awvalid_held",   m0_awvalid, 1'b1);
    m0_wready = 1'b0;
    idle_steps(2);
    m0_awready = 1'b1;
    idle_steps(3);
    chk("t2_retired", n_ret - n0, 1);
    chk("t2_idle_gnt", mem_gnt, 1'b1);

    // 3: fill to OUTSTANDING, fifth grant coincides with first retire
    m0_arready = 1'b1; r_allow = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < OUT; i++) begin
      cpu(1'b1, 1'b0, 32'h1000 + 32'(i) * 4, 32'h0, 4'h0);
      step();
      chk("t3_gnt_fill", s_gnt, 1'b1);
    end
    cpu(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
    step();
    chk("t3_gnt_full", s_gnt, 1'b0);
    r_allow = 1'b1;
    step();
    chk("t3_gnt_on_retire", s_gnt, 1'b1);
    chk("t3_recv_on_retire", s_recv, 1'b1);
    idle_steps(8);

    // 4: B arrives before R; write response must wait behind the read
    m0_arready = 1'b1; m0_awready = 1'b1; m0_wready = 1'b1;
    r_allow = 1'b0; b_allow = 1'b1; mem_ack = 1'b1;
    n0 = n_ret;
    cpu(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    step();
    cpu(1'b1, 1'b1, 32'h304, 32'hCAFE, 4'hF);
    step();
    idle_steps(4);
    chk("t4_bvalid_waiting", m0_bvalid, 1'b1);
    chk("t4_bready_held", s_bready, 1'b0);
    chk("t4_recv_held", s_recv, 1'b0);
    r_allow = 1'b1;
    idle_steps(4);
    chk("t4_retired", n_ret - n0, 2);

    // 5: error responses, then enable=0 while a read is in flight
    n0 = n_ret;
    cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step();
    idle_steps(4);
    chk("t5_rd_err", s_err, 1'b1);
    cpu(1'b1, 1'b1, 32'h20, 32'h55, 4'h1);
    step();
    idle_steps(4);
    chk("t5_wr_err", s_err, 1'b1);
    r_allow = 1'b0;
    cpu(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    step();
    enable = 1'b0;
    cpu(1'b1, 1'b1, 32'h404, 32'h1, 4'h1);
    step();
    chk("t5_gnt_disabled", s_gnt, 1'b0);
    r_allow = 1'b1;
    repeat (3) begin
      step();
      chk("t5_gnt_disabled_drain", s_gnt, 1'b0);
    end
    chk("t5_retired", n_ret - n0, 3);
    enable = 1'b1;
    idle_steps(2);

    // 6: asynchronous reset with traffic in flight
    m0_arready = 1'b1; r_allow = 1'b0; b_allow = 1'b0;
    cpu(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
    step();
    cpu(1'b1, 1'b0, 32'h504, 32'h0, 4'h0);
    step();
    m0_awready = 1'b0; m0_wready = 1'b0;
    cpu(1'b1, 1'b1, 32'h508, 32'h77, 4'hF);
    step();
    idle_steps(1);
    chk("t6_pre_valids", {m0_awvalid, m0_wvalid}, 2'b11);
    #2;
    m0_aresetn = 1'b0;
    #1;
    chk("t6_rst_valids",  {m0_arvalid, m0_awvalid, m0_wvalid}, 3'b000);
    chk("t6_rst_readies", {m0_bready, m0_rready}, 2'b00);
    chk("t6_rst_gnt",     mem_gnt, 1'b0);
    chk("t6_rst_recv",    mem_recv, 1'b0);
    model_clear();
    m0_rvalid = 1'b0; m0_bvalid = 1'b0;
    @(posedge m0_aclk);
    #1;
    m0_aresetn = 1'b1;
    m0_awready = 1'b1; m0_wready = 1'b1;
    single_read_dead();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable     = ($urandom_range(0, 7) != 0);
      mem_ack    = ($urandom_range(0, 3) != 0);
      m0_arready = $urandom_range(0, 1) == 1;
      m0_awready = $urandom_range(0, 1) == 1;
      m0_wready  = $urandom_range(0, 1) == 1;
      r_allow    = ($urandom_range(0, 4) > 1);
      b_allow    = ($urandom_range(0, 4) > 1);
      cpu($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
          $urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(0, 15)));
      step();
    end
    m0_arready = 1'b1; m0_awready = 1'b1; m0_wready = 1'b1;
    r_allow = 1'b1; b_allow = 1'b1; mem_ack = 1'b1; enable = 1'b1;
    idle_steps(20);
    chk("end_recv",   mem_recv, 1'b0);
    chk("end_valids", {m0_arvalid, m0_awvalid, m0_wvalid}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
